// File: rtl/click_pkg.sv
// Shared definitions for the click demux fabric and its synchronous sinks.
package click_pkg;

  typedef enum logic {
    SRC_B = 1'b0,
    SRC_C = 1'b1
  } src_e;

  function automatic int unsigned entry_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single 2-phase request bit, with configurable reset phase.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/click2sync_sink.sv
// Receives the B/C 2-phase bundled-data channels, returns acks and queues {src,data}
// into a valid/ready FIFO in the synchronous domain.
module click2sync_sink
  import click_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic        PHASE_INIT_B = 1'b0,
  parameter logic        PHASE_INIT_C = 1'b0,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inB_req,
  input  logic [DATA_WIDTH-1:0]         inB_data,
  output logic                          inB_ack,
  input  logic                          inC_req,
  input  logic [DATA_WIDTH-1:0]         inC_data,
  output logic                          inC_ack,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_src,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = entry_width(DATA_WIDTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic          req_sync_b, req_sync_c;
  logic          ack_b_q, ack_b_d, ack_c_q, ack_c_d;
  logic          pend_b, pend_c;
  logic          push, pop;
  src_e          grant;
  src_e          prio_q, prio_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] wr_entry;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(PHASE_INIT_B)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (inB_req),
    .q     (req_sync_b)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(PHASE_INIT_C)) u_sync_c (
    .clk   (clk),
    .reset (reset),
    .d     (inC_req),
    .q     (req_sync_c)
  );

  assign pend_b = req_sync_b ^ ack_b_q;
  assign pend_c = req_sync_c ^ ack_c_q;

  always_comb begin
    push     = 1'b0;
    grant    = SRC_B;
    ack_b_d  = ack_b_q;
    ack_c_d  = ack_c_q;
    prio_d   = prio_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = (count_q != '0) && out_ready;

    // Full blocks acceptance even if the head pops this cycle; the ack stays held.
    if (count_q < DEPTH_C) begin
      if (pend_b && pend_c) begin
        push  = 1'b1;
        grant = prio_q;
      end else if (pend_b) begin
        push  = 1'b1;
        grant = SRC_B;
      end else if (pend_c) begin
        push  = 1'b1;
        grant = SRC_C;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (grant == SRC_B) begin
        ack_b_d = ~ack_b_q;
        prio_d  = SRC_C;
      end else begin
        ack_c_d = ~ack_c_q;
        prio_d  = SRC_B;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  assign wr_entry = (grant == SRC_B) ? {1'b0, inB_data} : {1'b1, inC_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_b_q  <= PHASE_INIT_B;
      ack_c_q  <= PHASE_INIT_C;
      prio_q   <= SRC_B;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ack_b_q  <= ack_b_d;
      ack_c_q  <= ack_c_d;
      prio_q   <= prio_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
      end
    end
  end

  assign inB_ack    = ack_b_q;
  assign inC_ack    = ack_c_q;
  assign out_valid  = (count_q != '0);
  assign out_src    = mem_q[rd_ptr_q][EW-1];
  assign out_data   = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign fifo_count = count_q;

endmodule

// File: tb/tb_click2sync_sink.sv
// Scoreboard bench for click2sync_sink: per-channel expected queues filled at stimulus time.
module tb_click2sync_sink;
  localparam int   DW    = 32;
  localparam logic PIB   = 1'b1;
  localparam logic PIC   = 1'b0;
  localparam int   DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          inB_req, inC_req, inB_ack, inC_ack;
  logic [DW-1:0] inB_data, inC_data, out_data;
  logic          out_valid, out_src, out_ready;
  logic [2:0]    fifo_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_b[$];
  logic [DW-1:0] exp_c[$];
  logic          log_src[$];
  logic [DW-1:0] log_data[$];
  int tog_b = 0, tog_c = 0, req_b_n = 0, req_c_n = 0;
  logic prev_b, prev_c;
  bit   done_b, done_c;

  click2sync_sink #(
    .DATA_WIDTH   (DW),
    .PHASE_INIT_B (PIB),
    .PHASE_INIT_C (PIC),
    .FIFO_DEPTH   (DEPTH),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inB_req    (inB_req),
    .inB_data   (inB_data),
    .inB_ack    (inB_ack),
    .inC_req    (inC_req),
    .inC_data   (inC_data),
    .inC_ack    (inC_ack),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [DW-1:0] d);
    inB_data = d;
    exp_b.push_back(d);
    inB_req = ~inB_req;
    req_b_n++;
  endtask

  task automatic send_c(input logic [DW-1:0] d);
    inC_data = d;
    exp_c.push_back(d);
    inC_req = ~inC_req;
    req_c_n++;
  endtask

  task automatic wait_ack_b(input string name);
    int k = 0;
    while (inB_ack !== inB_req && k < 100) begin cyc(1); k++; end
    check(name, inB_ack, inB_req);
  endtask

  task automatic wait_ack_c(input string name);
    int k = 0;
    while (inC_ack !== inC_req && k < 100) begin cyc(1); k++; end
    check(name, inC_ack, inC_req);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (fifo_count != 0 && k < 200) begin cyc(1); k++; end
    cyc(1);
    check(name, {fifo_count, 8'(exp_b.size()), 8'(exp_c.size())}, '0);
  endtask

  // Monitor: pops the per-channel expectation whenever the head is consumed.
  initial begin
    logic [DW-1:0] e;
    prev_b = PIB;
    prev_c = PIC;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_b = inB_ack;
        prev_c = inC_ack;
      end else begin
        if (inB_ack !== prev_b) tog_b++;
        if (inC_ack !== prev_c) tog_c++;
        prev_b = inB_ack;
        prev_c = inC_ack;
        check("valid_vs_count", out_valid, fifo_count != 0);
        if (out_valid && out_ready) begin
          log_src.push_back(out_src);
          log_data.push_back(out_data);
          if (out_src == 1'b0) begin
            if (exp_b.size() == 0) begin
              checks++; errors++;
              $display("FAIL pop_b_unexpected got=%0h exp=none", out_data);
            end else begin
              e = exp_b.pop_front();
              check("pop_b_data", out_data, e);
            end
          end else begin
            if (exp_c.size() == 0) begin
              checks++; errors++;
              $display("FAIL pop_c_unexpected got=%0h exp=none", out_data);
            end else begin
              e = exp_c.pop_front();
              check("pop_c_data", out_data, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; inB_req = PIB; inC_req = PIC;
    inB_data = '0; inC_data = '0; out_ready = 1'b0;

    // Test 1: reset state and quiet interval
    cyc(1);
    check("rst_acks", {inB_ack, inC_ack}, {PIB, PIC});
    check("rst_out", {out_valid, fifo_count, out_src, out_data}, '0);
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("idle", {inB_ack, inC_ack, out_valid, fifo_count}, {PIB, PIC, 1'b0, 3'd0});
    end

    // Test 3: simultaneous B and C after reset, B has priority
    out_ready = 1'b0;
    log_src.delete();
    send_b(32'h1111);
    send_c(32'h2222);
    cyc(2);
    check("both_e2", {inB_ack, inC_ack}, {PIB, PIC});
    cyc(1);
    check("both_e3", {inB_ack, inC_ack}, {~PIB, PIC});
    cyc(1);
    check("both_e4", {inB_ack, inC_ack}, {~PIB, ~PIC});
    out_ready = 1'b1;
    drain("drain_both");
    check("both_order", {8'(log_src.size()), 7'd0, log_src[0], 7'd0, log_src[1]}, {8'd2, 8'd0, 8'd1});

    // Test 2: single B token latency
    send_b(32'hDEADBEEF);
    for (int e = 1; e <= 4; e++) begin
      cyc(1);
      if (e < 3) check("lat_pre", {inB_ack, out_valid}, {inB_req ^ 1'b1, 1'b0});
      else if (e == 3) check("lat_e3", {inB_ack, out_valid, out_src, out_data},
                             {inB_req, 1'b1, 1'b0, 32'hDEADBEEF});
      else check("lat_e4", {out_valid, fifo_count}, {1'b0, 3'd0});
    end

    // Test 4: fill to full, fifth ack held, then release
    out_ready = 1'b0;
    log_data.delete();
    for (int i = 0; i < 4; i++) begin
      send_b(DW'(i));
      wait_ack_b("fill_ack");
    end
    send_b(32'd4);
    cyc(10);
    check("full_held", {inB_ack ^ inB_req, fifo_count}, {1'b1, 3'd4});
    out_ready = 1'b1;
    wait_ack_b("full_release_ack");
    drain("drain_full");
    check("full_n", log_data.size(), 5);
    for (int i = 0; i < 5 && i < log_data.size(); i++) check("full_order", log_data[i], i);

    // Test 5: back-to-back on both channels; last grant was B so C leads
    log_src.delete();
    fork
      begin
        for (int r = 0; r < 8; r++) begin send_b($urandom); wait_ack_b("rr_ack_b"); end
      end
      begin
        for (int r = 0; r < 8; r++) begin send_c($urandom); wait_ack_c("rr_ack_c"); end
      end
    join
    drain("drain_rr");
    check("rr_n", log_src.size(), 16);
    for (int i = 0; i < 16 && i < log_src.size(); i++) check("rr_src", log_src[i], (i % 2) == 0);

    // Random traffic with random backpressure
    done_b = 0; done_c = 0;
    fork
      begin
        for (int r = 0; r < 20; r++) begin
          cyc($urandom_range(0, 5)); send_b($urandom); wait_ack_b("rnd_ack_b");
        end
        done_b = 1;
      end
      begin
        for (int r = 0; r < 20; r++) begin
          cyc($urandom_range(0, 5)); send_c($urandom); wait_ack_c("rnd_ack_c");
        end
        done_c = 1;
      end
      begin
        int k = 0;
        while (!(done_b && done_c) && k < 5000) begin out_ready = 1'($urandom); cyc(1); k++; end
      end
    join
    out_ready = 1'b1;
    drain("drain_rnd");
    check("ack_count_b", tog_b, req_b_n);
    check("ack_count_c", tog_c, req_c_n);

    // Test 6: reset with three queued and C in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin send_b(32'hA0 + i); wait_ack_b("pre_rst_ack"); end
    check("pre_rst_cnt", fifo_count, 3);
    send_c(32'hCC);
    cyc(1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid", {out_valid, fifo_count}, {1'b0, 3'd0});
    inB_req = PIB; inC_req = PIC;
    exp_b.delete(); exp_c.delete();
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("post_rst_idle", {inB_ack, inC_ack, out_valid}, {PIB, PIC, 1'b0});
    end
    out_ready = 1'b1;
    send_c(32'h5A5A5A5A);
    wait_ack_c("post_rst_ack");
    drain("drain_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
